// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle multiply/divide unit holding the architectural HI/LO
// registers. MULT/MULTU use iterative shift-add and DIV/DIVU use restoring
// division, one bit per cycle. A sign fix-up cycle follows. MTHI/MTLO write
// HI/LO directly.
// Optional feature macro: MULDIV_FAST_MUL_EN. When it is defined, multiplies use
// a single-cycle combinational multiplier and skip the iteration phase.
// Ports:
//   Clk, Reset          clock (rising edge); async active-low reset
//   Start, Op           launch request and opcode (0 MULT, 1 MULTU, 2 DIV,
//                       3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op)
//   DataIn1, DataIn2    rs / rt operands
//   Flush               abort the operation in flight
//   Busy, Done, DivZero status: engine active, result pulse, zero-divisor pulse
//   Hi, Lo              architectural HI / LO registers
module muldiv_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [2:0]       Op,
    input  logic [WIDTH-1:0] DataIn1,
    input  logic [WIDTH-1:0] DataIn2,
    input  logic             Flush,
    output logic             Busy,
    output logic             Done,
    output logic             DivZero,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);
    localparam int unsigned W2 = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;     // product upper half / partial remainder
    logic [WIDTH-1:0] wrk_q, wrk_d;     // multiplier bits / dividend->quotient bits
    logic [WIDTH-1:0] mag_q, mag_d;     // multiplicand or divisor magnitude
    logic [WIDTH-1:0] raw1_q, raw1_d;   // unmodified dividend for the divide-by-zero result
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             is_div_q, is_div_d;
    logic             neg_res_q, neg_res_d;
    logic             neg_rem_q, neg_rem_d;
    logic             dz_q, dz_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             divzero_q, divzero_d;

    logic             accept_c;
    logic             arith_c;
    logic             a_neg_c;
    logic             b_neg_c;
    logic [WIDTH-1:0] a_mag_c;
    logic [WIDTH-1:0] b_mag_c;
    logic [WIDTH:0]   mul_sum_c;
    logic [WIDTH:0]   div_shift_c;
    logic [WIDTH:0]   div_diff_c;
    logic [W2-1:0]    prod_c;

    // Operand magnitudes and single-step arithmetic for both engines
    always_comb begin : step_logic
        accept_c    = Start && !Flush && (state_q == S_IDLE);
        arith_c     = !Op[2];
        a_neg_c     = !Op[0] && DataIn1[WIDTH-1];
        b_neg_c     = !Op[0] && DataIn2[WIDTH-1];
        a_mag_c     = a_neg_c ? (~DataIn1 + WIDTH'(1)) : DataIn1;
        b_mag_c     = b_neg_c ? (~DataIn2 + WIDTH'(1)) : DataIn2;
        mul_sum_c   = {1'b0, acc_q} + (wrk_q[0] ? {1'b0, mag_q} : '0);
        div_shift_c = {acc_q, wrk_q[WIDTH-1]};
        // Top bit set means the trial subtraction borrowed (quotient bit 0)
        div_diff_c  = div_shift_c - {1'b0, mag_q};
        prod_c      = neg_res_q ? (~{acc_q, wrk_q} + W2'(1)) : {acc_q, wrk_q};
    end

    // State register
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; Flush overrides everything
    always_comb begin : next_state
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept_c && arith_c) begin
`ifdef MULDIV_FAST_MUL_EN
                    state_d = Op[1] ? S_CALC : S_FIX;
`else
                    state_d = S_CALC;
`endif
                end
            end
            S_CALC: begin
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (Flush) begin
            state_d = S_IDLE;
        end
    end

    // Datapath and output next values
    always_comb begin : outputs
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        wrk_d     = wrk_q;
        mag_d     = mag_q;
        raw1_d    = raw1_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        done_d    = 1'b0;
        divzero_d = 1'b0;
        busy_d    = (state_d != S_IDLE);

        if (!Flush) begin
            case (state_q)
                S_IDLE: begin
                    if (accept_c) begin
                        case (Op)
                            3'd4: hi_d = DataIn1;
                            3'd5: lo_d = DataIn1;
                            3'd0, 3'd1, 3'd2, 3'd3: begin
                                is_div_d  = Op[1];
                                neg_res_d = a_neg_c ^ b_neg_c;
                                neg_rem_d = a_neg_c;
                                raw1_d    = DataIn1;
                                dz_d      = Op[1] && (DataIn2 == '0);
                                cnt_d     = '0;
                                acc_d     = '0;
                                if (Op[1]) begin
                                    mag_d = b_mag_c;
                                    wrk_d = a_mag_c;
                                end else begin
                                    mag_d = a_mag_c;
                                    wrk_d = b_mag_c;
`ifdef MULDIV_FAST_MUL_EN
                                    {acc_d, wrk_d} = W2'(a_mag_c) * W2'(b_mag_c);
`endif
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                S_CALC: begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (is_div_q) begin
                        acc_d = div_diff_c[WIDTH] ? div_shift_c[WIDTH-1:0]
                                                  : div_diff_c[WIDTH-1:0];
                        wrk_d = {wrk_q[WIDTH-2:0], ~div_diff_c[WIDTH]};
                    end else begin
                        acc_d = mul_sum_c[WIDTH:1];
                        wrk_d = {mul_sum_c[0], wrk_q[WIDTH-1:1]};
                    end
                end
                S_FIX: begin
                    done_d = 1'b1;
                    if (is_div_q) begin
                        if (dz_q) begin
                            hi_d      = raw1_q;
                            lo_d      = '1;
                            divzero_d = 1'b1;
                        end else begin
                            lo_d = neg_res_q ? (~wrk_q + WIDTH'(1)) : wrk_q;
                            hi_d = neg_rem_q ? (~acc_q + WIDTH'(1)) : acc_q;
                        end
                    end else begin
                        {hi_d, lo_d} = prod_c;
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath and output registers
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            cnt_q     <= '0;
            acc_q     <= '0;
            wrk_q     <= '0;
            mag_q     <= '0;
            raw1_q    <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            divzero_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            wrk_q     <= wrk_d;
            mag_q     <= mag_d;
            raw1_q    <= raw1_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            divzero_q <= divzero_d;
        end
    end

    assign Busy    = busy_q;
    assign Done    = done_q;
    assign DivZero = divzero_q;
    assign Hi      = hi_q;
    assign Lo      = lo_q;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers for the MIPS core. It extends the datapath beyond the single-cycle ALU with MULT/MULTU/DIV/DIVU and MTHI/MTLO, using an iterative radix-2 engine and a Start/Busy/Done handshake. The controller stalls the PC while Busy is high. MFHI/MFLO read the Hi/Lo ports through the existing writeback mux.

Parameters:
WIDTH, 32, operand width; Hi and Lo are WIDTH bits each
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH

Ports:
Clk  in  1  clock, rising edge
Reset  in  1  asynchronous, active-low reset
Start  in  1  launch request, sampled when Busy=0
Op  in  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO, 6-7 reserved (no-op)
DataIn1  in  WIDTH  rs operand (multiplicand/dividend; MTHI/MTLO source)
DataIn2  in  WIDTH  rt operand (multiplier/divisor)
Flush  in  1  abort the operation in flight
Busy  out  1  high while the engine is iterating
Done  out  1  one-cycle pulse; Hi/Lo hold the new result
DivZero  out  1  one-cycle pulse with Done when divisor was 0
Hi  out  WIDTH  HI register
Lo  out  WIDTH  LO register

Behaviour:
- Reset (Reset=0, async): state IDLE, Busy=0, Done=0, DivZero=0, Hi=0, Lo=0, counter=0.
- States: IDLE, CALC, FIX.
- IDLE + Start + Op in {0..3}: latch the operand magnitudes (signed ops take the absolute value) and the sign bits, clear the partial result, counter=0, go to CALC. Busy goes high on the next cycle.
- IDLE + Start + Op=4/5: Hi (or Lo) <= DataIn1 at that edge. Busy stays 0, Done stays 0.
- IDLE + Start + Op=6/7: ignored.
- CALC:
  - Multiply: shift-add, one multiplier bit per cycle.
  - Divide: restoring division, one quotient bit per cycle.
  - After WIDTH cycles (counter==WIDTH-1), go to FIX.
- FIX, one cycle:
  - Signed multiply: negate the 2*WIDTH product if the signs differ.
  - Signed divide: quotient negated if the signs differ; remainder takes the dividend's sign.
  - Write Hi=upper/remainder and Lo=lower/quotient.
  - Assert Done for one cycle and return to IDLE.
- Latency: Start accepted at edge k → Busy=1 for edges k+1..k+WIDTH+1 → Done=1 and Hi/Lo valid in the cycle following edge k+WIDTH+1. Total WIDTH+1 busy cycles.
- Start while Busy=1 is ignored, not queued.
- Divide by zero: iteration still runs the full length. Result forced to Hi=DataIn1 (as latched), Lo=all ones. DivZero pulses together with Done.
- Signed overflow (most-negative / -1): Lo=most-negative, Hi=0. No flag.
- Flush (any state): return to IDLE next edge. Hi/Lo unchanged, Done not asserted. Flush has priority over Start in the same cycle.
- Reset asserted mid-operation: immediate return to the reset values.
- Hi/Lo change only at FIX or MTHI/MTLO. They are stable otherwise, including during CALC.

Optional Feature:
MULDIV_FAST_MUL_EN:
- Defined: MULT/MULTU use a single-cycle combinational WIDTH×WIDTH multiplier. CALC is skipped (IDLE→FIX), so Busy is high for 1 cycle and Done follows 2 edges after Start. Division is unchanged.
- Undefined: multiply is iterative, with the same WIDTH+1 latency as divide.

Test Plan:
1. Reset low mid-CALC of DIV → Busy=0, Done=0, Hi=Lo=0 immediately; Start afterwards works normally.
2. MULT 0xFFFFFFFE × 0x00000003, WIDTH=32 → Done after 33 busy cycles; Hi=0xFFFFFFFF, Lo=0xFFFFFFFA. MULTU with the same operands → Hi=0x00000002, Lo=0xFFFFFFFA.
3. DIV -7 (0xFFFFFFF9) / 2 → Lo=0xFFFFFFFD (-3), Hi=0xFFFFFFFF (-1). DIVU 100/7 → Lo=14, Hi=2.
4. DIVU 0x1234/0 → Done with DivZero=1, Hi=0x00001234, Lo=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF → Lo=0x80000000, Hi=0.
5. MTHI 0xAAAA5555, then MTLO 0x5555AAAA in consecutive cycles → Hi/Lo updated at each edge, Busy never high. Start(MULT) during Busy → ignored, first result intact.
6. Flush at cycle 10 of DIVU with Hi=Lo=0x11111111 beforehand → IDLE next edge, no Done, Hi/Lo still 0x11111111. With MULDIV_FAST_MUL_EN: MULTU 6×7 → Lo=42, Done two edges after Start.
